// File: rtl/gaplus_cen_pkg.sv
// gaplus_cen_pkg
//   Shared types and helpers for the clock-enable generator.
//   inc_t     : increment word at the default accumulator width
//   INC_HALF  : half of the accumulator range, the fastest legal increment
//   clamp_inc : limits an increment to half range so that rising and
//               falling enables can never land on the same edge
package gaplus_cen_pkg;

  localparam int ACCW_DEF = 16;

  typedef logic [ACCW_DEF-1:0] inc_t;

  localparam inc_t INC_HALF = inc_t'(1) << (ACCW_DEF - 1);

  // Width-generic clamp: min(v, 2^(w-1)). Valid for accumulator widths up to 31.
  function automatic logic [31:0] clamp_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = 32'd1 << (w - 1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/gaplus_cen_chan.sv
// gaplus_cen_chan
//   One fractional-phase clock-enable channel.
//   MCLK    : master clock
//   RESET   : asynchronous active-high reset
//   sync    : restart phase, commit any pending increment
//   hold    : freeze this channel (sync still wins)
//   cfg_we  : increment write aimed at this channel
//   cfg_inc : raw increment, clamped here before storage
//   cen     : one-cycle enable on accumulator carry
//   cenb    : one-cycle enable when the phase crosses the half point
//   clko    : square clock, set by cen, cleared by cenb
//   pend    : a written increment waits for the next carry
module gaplus_cen_chan
  import gaplus_cen_pkg::*;
#(
  parameter int              ACCW    = 16,
  parameter logic [ACCW-1:0] INC_RST = {1'b1, {(ACCW-1){1'b0}}}
) (
  input  logic            MCLK,
  input  logic            RESET,
  input  logic            sync,
  input  logic            hold,
  input  logic            cfg_we,
  input  logic [ACCW-1:0] cfg_inc,
  output logic            cen,
  output logic            cenb,
  output logic            clko,
  output logic            pend
);

  logic [ACCW-1:0] acc_reg, acc_next;
  logic [ACCW-1:0] inc_reg, inc_next;
  logic [ACCW-1:0] shadow_reg, shadow_next;
  logic            pend_reg, pend_next;
  logic            cen_reg, cen_next;
  logic            cenb_reg, cenb_next;
  logic            clko_reg, clko_next;

  logic [ACCW-1:0] inc_clamped;
  logic [ACCW:0]   sum;
  logic            carry;
  logic            half_cross;

  assign inc_clamped = ACCW'(clamp_inc(32'(cfg_inc), ACCW));
  assign sum         = {1'b0, acc_reg} + {1'b0, inc_reg};
  assign carry       = sum[ACCW];
  // Half-point crossing without a wrap; the clamp keeps this disjoint from carry.
  assign half_cross  = ~acc_reg[ACCW-1] & sum[ACCW-1] & ~carry;

  always_comb begin
    acc_next    = acc_reg;
    inc_next    = inc_reg;
    shadow_next = shadow_reg;
    pend_next   = pend_reg;
    cen_next    = 1'b0;
    cenb_next   = 1'b0;
    clko_next   = clko_reg;

    if (sync) begin
      acc_next  = '0;
      clko_next = 1'b0;
      pend_next = 1'b0;
      if (pend_reg) begin
        inc_next = shadow_reg;
      end
      // A write coinciding with sync bypasses the shadow entirely.
      if (cfg_we) begin
        inc_next    = inc_clamped;
        shadow_next = inc_clamped;
      end
    end else begin
      if (!hold) begin
        acc_next  = sum[ACCW-1:0];
        cen_next  = carry;
        cenb_next = half_cross;
        if (carry) begin
          clko_next = 1'b1;
        end else if (half_cross) begin
          clko_next = 1'b0;
        end
        // Commit on the carrying edge; that update already used the old rate,
        // and acc is untouched so the phase stays continuous.
        if (carry && pend_reg) begin
          inc_next  = shadow_reg;
          pend_next = 1'b0;
        end
      end
      // A write on the commit edge re-arms with the new value.
      if (cfg_we) begin
        shadow_next = inc_clamped;
        pend_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      acc_reg    <= '0;
      inc_reg    <= INC_RST;
      shadow_reg <= '0;
      pend_reg   <= 1'b0;
      cen_reg    <= 1'b0;
      cenb_reg   <= 1'b0;
      clko_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      inc_reg    <= inc_next;
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
      cen_reg    <= cen_next;
      cenb_reg   <= cenb_next;
      clko_reg   <= clko_next;
    end
  end

  assign cen  = cen_reg;
  assign cenb = cenb_reg;
  assign clko = clko_reg;
  assign pend = pend_reg;

endmodule

// File: rtl/gaplus_cen_gen.sv
// gaplus_cen_gen
//   Multi-channel programmable clock-enable generator.
//   MCLK    : master clock
//   RESET   : asynchronous active-high reset
//   SYNC    : restart all channel phases together
//   HOLD    : per-channel freeze
//   CFG_WE  : increment write strobe
//   CFG_CH  : channel addressed by the write (out-of-range ignored)
//   CFG_INC : new increment
//   CEN     : rising-phase enables
//   CENB    : falling-phase enables
//   CLKO    : derived square clocks
//   PEND    : per-channel pending-increment flags
module gaplus_cen_gen
  import gaplus_cen_pkg::*;
#(
  parameter int                   NCH      = 4,
  parameter int                   ACCW     = 16,
  parameter logic [NCH*ACCW-1:0]  INC_INIT = {16'h1000, 16'h2000, 16'h4000, 16'h8000}
) (
  input  logic                   MCLK,
  input  logic                   RESET,
  input  logic                   SYNC,
  input  logic [NCH-1:0]         HOLD,
  input  logic                   CFG_WE,
  input  logic [$clog2(NCH)-1:0] CFG_CH,
  input  logic [ACCW-1:0]        CFG_INC,
  output logic [NCH-1:0]         CEN,
  output logic [NCH-1:0]         CENB,
  output logic [NCH-1:0]         CLKO,
  output logic [NCH-1:0]         PEND
);

  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] ch_we;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      // Channel numbers that do not exist never match, so such writes drop.
      assign ch_we[gi] = CFG_WE && (CFG_CH == CHW'(gi));

      gaplus_cen_chan #(
        .ACCW    (ACCW),
        .INC_RST (INC_INIT[gi*ACCW +: ACCW])
      ) u_chan (
        .MCLK    (MCLK),
        .RESET   (RESET),
        .sync    (SYNC),
        .hold    (HOLD[gi]),
        .cfg_we  (ch_we[gi]),
        .cfg_inc (CFG_INC),
        .cen     (CEN[gi]),
        .cenb    (CENB[gi]),
        .clko    (CLKO[gi]),
        .pend    (PEND[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gaplus_cen_gen.sv
module tb_gaplus_cen_gen;
  import gaplus_cen_pkg::*;

  localparam int NCH = 4;
  localparam int ACCW = 16;
  localparam int M = 65536;
  localparam int H = int'(INC_HALF);

  logic       MCLK = 1'b0;
  logic       RESET;
  logic       SYNC;
  logic [3:0] HOLD;
  logic       CFG_WE;
  logic [1:0] CFG_CH;
  inc_t       CFG_INC;
  logic [3:0] CEN, CENB, CLKO, PEND;

  always #5 MCLK = ~MCLK;

  gaplus_cen_gen #(
    .NCH      (NCH),
    .ACCW     (ACCW),
    .INC_INIT ({16'h1000, 16'h2000, 16'h4000, 16'h8000})
  ) dut (
    .MCLK    (MCLK),
    .RESET   (RESET),
    .SYNC    (SYNC),
    .HOLD    (HOLD),
    .CFG_WE  (CFG_WE),
    .CFG_CH  (CFG_CH),
    .CFG_INC (CFG_INC),
    .CEN     (CEN),
    .CENB    (CENB),
    .CLKO    (CLKO),
    .PEND    (PEND)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase as a plain integer in [0, 2^16).
  int m_acc[4];
  int m_inc[4];
  int m_sh[4];
  bit m_pend[4], m_cen[4], m_cenb[4], m_clko[4];
  int init_inc[4] = '{32'h8000, 32'h4000, 32'h2000, 32'h1000};

  function automatic int clampm(input int v);
    return (v > H) ? H : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_inc[i] = init_inc[i]; m_sh[i] = 0;
      m_pend[i] = 0; m_cen[i] = 0; m_cenb[i] = 0; m_clko[i] = 0;
    end
  endtask

  task automatic model_edge();
    int nxt;
    bit carry, half;
    if (RESET) begin
      model_reset();
      return;
    end
    if (SYNC) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = 0; m_cen[i] = 0; m_cenb[i] = 0; m_clko[i] = 0;
        if (m_pend[i]) m_inc[i] = m_sh[i];
        m_pend[i] = 0;
      end
      if (CFG_WE) m_inc[CFG_CH] = clampm(int'(CFG_INC));
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (HOLD[i]) begin
        m_cen[i] = 0; m_cenb[i] = 0;
      end else begin
        nxt   = m_acc[i] + m_inc[i];
        carry = (nxt >= M);
        half  = !carry && (m_acc[i] < H) && (nxt >= H);
        m_acc[i]  = nxt % M;
        m_cen[i]  = carry;
        m_cenb[i] = half;
        if (carry) m_clko[i] = 1;
        else if (half) m_clko[i] = 0;
        if (carry && m_pend[i]) begin
          m_inc[i] = m_sh[i];
          m_pend[i] = 0;
        end
      end
      if (CFG_WE && (int'(CFG_CH) == i)) begin
        m_sh[i] = clampm(int'(CFG_INC));
        m_pend[i] = 1;
      end
    end
  endtask

  function automatic logic [15:0] mexp();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i] = m_cen[i]; v[4+i] = m_cenb[i]; v[8+i] = m_clko[i]; v[12+i] = m_pend[i];
    end
    return v;
  endfunction

  // One MCLK edge: advance model with the inputs the DUT sampled, then compare.
  task automatic step();
    @(posedge MCLK);
    model_edge();
    #1;
    cyc++;
    chk("model", {16'h0, PEND, CLKO, CENB, CEN}, {16'h0, mexp()});
  endtask

  // Steps until CEN[ch] is seen; returns the number of edges, bounded by max.
  task automatic wait_cen(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!CEN[ch] && n < max);
  endtask

  typedef struct {
    logic [3:0] hold;
    logic [3:0] cen;
    logic [3:0] cenb;
    logic [3:0] clko;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, n0, bad, first3, second3;

    tbl[0] = '{hold: 4'b0000, cen: 4'b0000, cenb: 4'b0001, clko: 4'b0000};
    tbl[1] = '{hold: 4'b0000, cen: 4'b0011 & 4'b0001, cenb: 4'b0010, clko: 4'b0001};
    tbl[2] = '{hold: 4'b0000, cen: 4'b0000, cenb: 4'b0001, clko: 4'b0000};
    tbl[3] = '{hold: 4'b0000, cen: 4'b0011, cenb: 4'b0100, clko: 4'b0011};
    tbl[4] = '{hold: 4'b0111, cen: 4'b0000, cenb: 4'b0000, clko: 4'b0011};
    tbl[5] = '{hold: 4'b0000, cen: 4'b0000, cenb: 4'b0001, clko: 4'b0010};

    RESET = 1'b1; SYNC = 1'b0; HOLD = 4'b0; CFG_WE = 1'b0; CFG_CH = 2'd0; CFG_INC = '0;
    model_reset();
    repeat (3) step();
    chk("reset_state", {16'h0, PEND, CLKO, CENB, CEN}, 32'h0);

    // Release and walk the first cycles from a table.
    RESET = 1'b0;
    cyc = 0;
    first3 = 0; second3 = 0;
    for (int k = 0; k < 6; k++) begin
      HOLD = tbl[k].hold;
      step();
      chk("tbl_cen",  {28'h0, CEN},  {28'h0, tbl[k].cen});
      chk("tbl_cenb", {28'h0, CENB}, {28'h0, tbl[k].cenb});
      chk("tbl_clko", {28'h0, CLKO}, {28'h0, tbl[k].clko});
    end
    HOLD = 4'b0;
    while (cyc < 40) begin
      step();
      if (CEN[3]) begin
        if (first3 == 0) first3 = cyc;
        else if (second3 == 0) second3 = cyc;
      end
    end
    chk("ch3_first_cen", first3, 16);
    chk("ch3_second_cen", second3, 32);

    // ch1 rate 3/16: exact count over a 160-cycle window.
    CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_INC = 16'h3000;
    step();
    CFG_WE = 1'b0;
    chk("pend1_set", {31'h0, PEND[1]}, 1);
    n = 0;
    while (PEND[1] && n < 40) begin step(); n++; end
    chk("pend1_clear", {31'h0, PEND[1]}, 0);
    n = 0;
    for (int k = 0; k < 160; k++) begin
      step();
      if (CEN[1]) n++;
    end
    chk("ch1_cen_count", n, 30);

    // ch2 over-range write clamps to MCLK/2.
    CFG_WE = 1'b1; CFG_CH = 2'd2; CFG_INC = 16'hFFFF;
    step();
    CFG_WE = 1'b0;
    chk("pend2_set", {31'h0, PEND[2]}, 1);
    wait_cen(2, 20, n);
    chk("ch2_cen_seen", {31'h0, CEN[2]}, 1);
    chk("pend2_clear_at_cen", {31'h0, PEND[2]}, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (CEN[2]) n++;
    end
    chk("ch2_half_rate", n, 4);

    // ch3 hold mid-period.
    wait_cen(3, 40, n);
    chk("ch3_cen_before_hold", {31'h0, CEN[3]}, 1);
    repeat (5) step();
    HOLD = 4'b1000;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (CEN[3] || CENB[3] || !CLKO[3]) bad++;
    end
    chk("ch3_hold_frozen", bad, 0);
    HOLD = 4'b0;
    wait_cen(3, 40, n);
    chk("ch3_resume_interval", n, 11);

    // SYNC with pending writes on ch0 and ch1.
    CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_INC = 16'h4000;
    step();
    CFG_CH = 2'd0; CFG_INC = 16'h2000;
    step();
    CFG_WE = 1'b0;
    chk("pend0_before_sync", {31'h0, PEND[0]}, 1);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("sync_clear", {20'h0, PEND, CLKO, CEN}, 32'h0);
    n0 = 0; bad = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (CEN[0]) begin
        n0++;
        if (!CEN[2] || (k % 8) != 0) bad++;
      end
    end
    chk("sync_ch0_count", n0, 4);
    chk("sync_ch0_ch2_align", bad, 0);

    // SYNC coinciding with a write: applied directly, no pending.
    SYNC = 1'b1; CFG_WE = 1'b1; CFG_CH = 2'd3; CFG_INC = 16'h2000;
    step();
    SYNC = 1'b0; CFG_WE = 1'b0;
    chk("sync_we_pend3", {31'h0, PEND[3]}, 0);
    wait_cen(3, 40, n);
    chk("sync_we_ch3_interval", n, 8);

    // Asynchronous reset between edges while ch1 is pending.
    CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_INC = 16'h1000;
    step();
    CFG_WE = 1'b0;
    chk("pend1_before_reset", {31'h0, PEND[1]}, 1);
    #3;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("async_reset_clear", {16'h0, PEND, CLKO, CENB, CEN}, 32'h0);
    step();
    RESET = 1'b0;
    wait_cen(1, 20, n);
    chk("ch1_init_rate_after_reset", n, 4);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      SYNC = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) HOLD[i] = ($urandom_range(0, 7) == 0);
      CFG_WE = ($urandom_range(0, 9) == 0);
      CFG_CH = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: CFG_INC = 16'($urandom);
        1: CFG_INC = 16'h0;
        default: CFG_INC = 16'($urandom_range(0, 16'h9000));
      endcase
      step();
    end
    SYNC = 1'b0; HOLD = 4'b0; CFG_WE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
